// File: rtl/multicycle_control_pkg.sv
// riscv_defs: shared definitions for the multicycle RV32I control path.
//   - opcode constants for the supported instruction classes
//   - FSM state encoding (also driven on the debug `state` output)
//   - ALUCtrl operation codes, identical to the datapath ALU's encoding
package riscv_defs;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  // Shared R/I funct3 table. sub_sel picks SUB for funct3=000 (R-type
  // only); sra_sel picks SRA for funct3=101 (both R and I). funct3=011
  // (SLTU) is not supported and falls back to ADD.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3,
                                                 input logic sub_sel,
                                                 input logic sra_sel);
    logic [3:0] op;
    op = ALU_ADD;
    case (funct3)
      3'b000:  op = sub_sel ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = sra_sel ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// alu_decoder: combinational instruction -> ALUCtrl mapping.
// Ports:
//   instr     in  32  current instruction
//   alu_ctrl  out 4   ALU operation code (riscv_defs ALU_* constants)
module alu_decoder
  import riscv_defs::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  alu_ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7_b5 = instr[30];

  // Register/immediate fields are irrelevant to the ALU operation.
  logic unused_fields;
  assign unused_fields = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (opcode)
      OP_R:          alu_ctrl = alu_from_funct3(funct3, funct7_b5, funct7_b5);
      // Bit 30 is immediate data for ADDI, so only SRAI looks at it.
      OP_I:          alu_ctrl = alu_from_funct3(funct3, 1'b0, funct7_b5);
      OP_LW, OP_SW:  alu_ctrl = ALU_ADD;
      OP_BEQ:        alu_ctrl = ALU_SUB;
      default:       alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: IF/ID/EX/MEM/WB sequencer for an RV32I multicycle
// datapath (R, I-ALU, LW, SW, BEQ). Unknown opcodes walk all five states
// and only update the PC.
// Parameters:
//   MEM_WAIT  extra cycles spent in MEM (0..15)
// Ports:
//   clk       in  1   clock, rising edge
//   rst       in  1   synchronous active-high reset
//   instr     in  32  instruction, stable from ID through WB
//   Zero      in  1   ALU zero flag, captured at the end of EX
//   PCSrc     out 1   1 = PC+branch offset, 0 = PC+4 (qualified by loadPC)
//   ALUSrc    out 1   1 = immediate operand
//   RegWrite  out 1   register-file write strobe (WB)
//   MemToReg  out 1   1 = write back memory data
//   MemWrite  out 1   data-memory write strobe (last MEM cycle)
//   ALUCtrl   out 4   ALU operation code
//   loadPC    out 1   PC update strobe (WB)
//   state     out 3   current FSM state (debug)
module multicycle_control
  import riscv_defs::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        MemWrite,
  output logic [3:0]  ALUCtrl,
  output logic        loadPC,
  output logic [2:0]  state
);

  localparam logic [3:0] MEM_WAIT_W = 4'(MEM_WAIT);

  state_t     st, nxt_state;
  logic [3:0] wait_cnt, nxt_wait;
  logic       zero_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_lw, is_sw, is_beq;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_beq = (opcode == OP_BEQ);

  logic unused_instr;
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  // Level outputs depend only on the instruction.
  assign ALUSrc   = is_i | is_lw | is_sw;
  assign MemToReg = is_lw;
  assign state    = st;

  alu_decoder u_alu_decoder (
    .instr    (instr),
    .alu_ctrl (ALUCtrl)
  );

  // The wait counter is loaded when EX hands over to MEM; the cycle in
  // which it reads zero is the last MEM cycle.
  always_comb begin
    nxt_state = st;
    nxt_wait  = wait_cnt;
    case (st)
      ST_IF:  nxt_state = ST_ID;
      ST_ID:  nxt_state = ST_EX;
      ST_EX: begin
        nxt_state = ST_MEM;
        nxt_wait  = MEM_WAIT_W;
      end
      ST_MEM: begin
        if (wait_cnt == 4'd0) nxt_state = ST_WB;
        else                  nxt_wait  = wait_cnt - 4'd1;
      end
      ST_WB:  nxt_state = ST_IF;
      default: nxt_state = ST_IF;
    endcase
  end

  // Strobes are registered from the state being entered, so each is high
  // for exactly the cycle the FSM spends in the qualifying state.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IF;
      wait_cnt <= 4'd0;
      zero_q   <= 1'b0;
      loadPC   <= 1'b0;
      PCSrc    <= 1'b0;
      RegWrite <= 1'b0;
      MemWrite <= 1'b0;
    end else begin
      st       <= nxt_state;
      wait_cnt <= nxt_wait;
      if (st == ST_EX) zero_q <= Zero;
      loadPC   <= (nxt_state == ST_WB);
      PCSrc    <= (nxt_state == ST_WB) && is_beq && (funct3 == 3'b000) && zero_q;
      RegWrite <= (nxt_state == ST_WB) && (is_r || is_i || is_lw);
      MemWrite <= (nxt_state == ST_MEM) && (nxt_wait == 4'd0) && is_sw;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] instr;
  logic        Zero;

  logic       pcsrc0, alusrc0, regwrite0, memtoreg0, memwrite0, loadpc0;
  logic [3:0] aluctrl0;
  logic [2:0] state0;
  logic       pcsrc1, alusrc1, regwrite1, memtoreg1, memwrite1, loadpc1;
  logic [3:0] aluctrl1;
  logic [2:0] state1;

  multicycle_control u_dut0 (
    .clk(clk), .rst(rst), .instr(instr), .Zero(Zero),
    .PCSrc(pcsrc0), .ALUSrc(alusrc0), .RegWrite(regwrite0),
    .MemToReg(memtoreg0), .MemWrite(memwrite0), .ALUCtrl(aluctrl0),
    .loadPC(loadpc0), .state(state0)
  );

  multicycle_control #(.MEM_WAIT(3)) u_dut1 (
    .clk(clk), .rst(rst), .instr(instr), .Zero(Zero),
    .PCSrc(pcsrc1), .ALUSrc(alusrc1), .RegWrite(regwrite1),
    .MemToReg(memtoreg1), .MemWrite(memwrite1), .ALUCtrl(aluctrl1),
    .loadPC(loadpc1), .state(state1)
  );

  // {state, loadPC, PCSrc, RegWrite, MemWrite, ALUSrc, MemToReg, ALUCtrl}
  localparam int W = 13;
  logic [W-1:0] word0, word1;
  assign word0 = {state0, loadpc0, pcsrc0, regwrite0, memwrite0, alusrc0, memtoreg0, aluctrl0};
  assign word1 = {state1, loadpc1, pcsrc1, regwrite1, memwrite1, alusrc1, memtoreg1, aluctrl1};

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] instr;
    logic        zero_ex;
    int          sel;      // 0: MEM_WAIT=0 instance, 1: MEM_WAIT=3 instance
    logic        alusrc;
    logic        mtr;
    logic [3:0]  alu;
    logic        rw;
    logic        mw;
    logic        pc;
  } vec_t;

  vec_t vecs[$];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic z, input int s,
                              input logic as, input logic m2r, input logic [3:0] a,
                              input logic rw, input logic mw, input logic pc);
    vec_t v;
    v.instr = i; v.zero_ex = z; v.sel = s; v.alusrc = as; v.mtr = m2r;
    v.alu = a; v.rw = rw; v.mw = mw; v.pc = pc;
    return v;
  endfunction

  // Expected outputs in cycle k of an instruction on an instance with mw
  // extra MEM cycles: IF, ID, EX, MEM x (1+mw), WB.
  function automatic logic [W-1:0] model(input int k, input int mw, input vec_t v);
    logic [2:0] st;
    logic       in_wb, last_mem;
    if (k == 0)            st = 3'd0;
    else if (k == 1)       st = 3'd1;
    else if (k == 2)       st = 3'd2;
    else if (k <= 3 + mw)  st = 3'd3;
    else                   st = 3'd4;
    in_wb    = (st == 3'd4);
    last_mem = (st == 3'd3) && (k == 3 + mw);
    return {st, in_wb, in_wb & v.pc, in_wb & v.rw, last_mem & v.mw, v.alusrc, v.mtr, v.alu};
  endfunction

  // Reference ALUCtrl for R/I-type funct3 (bench-side table).
  function automatic logic [3:0] ref_alu(input logic is_r, input logic [2:0] f3, input logic b5);
    case (f3)
      3'b000:  return (is_r && b5) ? 4'b0110 : 4'b0010;
      3'b001:  return 4'b1001;
      3'b010:  return 4'b0111;
      3'b100:  return 4'b0101;
      3'b101:  return b5 ? 4'b1010 : 4'b1000;
      3'b110:  return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Entry/exit point: 1 time unit after a rising edge, FSM of the selected
  // instance in IF. n=0 runs the whole instruction. rst is raised after the
  // check of cycle rst_at (use -1 for none).
  task automatic run_instr(input vec_t v, input int n, input int rst_at, input string nm);
    int mw, total;
    logic [W-1:0] got, exp;
    mw    = (v.sel != 0) ? 3 : 0;
    total = 5 + mw;
    if (n == 0 || n > total) n = total;
    instr = v.instr;
    for (int k = 0; k < n; k++) exp_q.push_back(model(k, mw, v));
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      got = (v.sel != 0) ? word1 : word0;
      exp = exp_q.pop_front();
      check($sformatf("%s[c%0d]", nm, k), got, exp);
      // Zero is only meaningful in EX; drive its inverse elsewhere so a
      // capture in the wrong cycle is visible.
      Zero = (k == 2) ? v.zero_ex : ~v.zero_ex;
      if (k == rst_at) rst = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    Zero  = 1'b0;
    instr = 32'h0000_0013;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  // ---------------- test ----------------
  initial begin
    vec_t v;
    logic is_r, b5;
    logic [2:0] f3;
    logic [31:0] ri;

    vecs.push_back(mk(32'h00500093, 1'b0, 0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0)); // addi
    vecs.push_back(mk(32'h002081B3, 1'b0, 0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0)); // add
    vecs.push_back(mk(32'h402081B3, 1'b0, 0, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0)); // sub
    vecs.push_back(mk(32'h0080A283, 1'b0, 0, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0)); // lw
    vecs.push_back(mk(32'h0050A623, 1'b0, 0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0)); // sw
    vecs.push_back(mk(32'h00208463, 1'b1, 0, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b1)); // beq taken
    vecs.push_back(mk(32'h00208463, 1'b0, 0, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0)); // beq not taken
    vecs.push_back(mk(32'h00209463, 1'b1, 0, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0)); // bne form: no branch
    vecs.push_back(mk(32'h0000007F, 1'b1, 0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0)); // illegal
    vecs.push_back(mk(32'h4030D093, 1'b0, 0, 1'b1, 1'b0, 4'b1010, 1'b1, 1'b0, 1'b0)); // srai
    vecs.push_back(mk(32'h40000093, 1'b0, 0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0)); // addi imm bit30
    vecs.push_back(mk(32'h002091B3, 1'b0, 0, 1'b0, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0)); // sll
    vecs.push_back(mk(32'h0020A1B3, 1'b0, 0, 1'b0, 1'b0, 4'b0111, 1'b1, 1'b0, 1'b0)); // slt
    vecs.push_back(mk(32'h0050C093, 1'b0, 0, 1'b1, 1'b0, 4'b0101, 1'b1, 1'b0, 1'b0)); // xori
    vecs.push_back(mk(32'h0020D1B3, 1'b0, 0, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0)); // srl
    vecs.push_back(mk(32'h4020D1B3, 1'b0, 0, 1'b0, 1'b0, 4'b1010, 1'b1, 1'b0, 1'b0)); // sra
    vecs.push_back(mk(32'h0050E093, 1'b0, 0, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0)); // ori
    vecs.push_back(mk(32'h0020F1B3, 1'b0, 0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0)); // and

    apply_reset();
    check("reset_u0", W'({state0, loadpc0, pcsrc0, regwrite0, memwrite0}), W'(0));
    check("reset_u1", W'({state1, loadpc1, pcsrc1, regwrite1, memwrite1}), W'(0));

    // Table vectors back to back on the MEM_WAIT=0 instance.
    foreach (vecs[i]) run_instr(vecs[i], 0, -1, $sformatf("vec%0d_%h", i, vecs[i].instr));

    // Randomised R/I ALU instructions.
    for (int r = 0; r < 8; r++) begin
      is_r = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      if (f3 == 3'b011) f3 = 3'b000;
      b5   = 1'($urandom_range(0, 1));
      ri   = {1'b0, b5, 5'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              f3, 5'($urandom_range(1, 31)), is_r ? 7'b0110011 : 7'b0010011};
      v = mk(ri, 1'($urandom_range(0, 1)), 0, ~is_r, 1'b0, ref_alu(is_r, f3, b5), 1'b1, 1'b0, 1'b0);
      run_instr(v, 0, -1, $sformatf("rand%0d_%h", r, ri));
    end

    // MEM_WAIT=3: sw holds MEM four cycles, write in the fourth, 8 total.
    apply_reset();
    v = mk(32'h0050A623, 1'b0, 1, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0);
    run_instr(v, 0, -1, "sw_wait3");
    check("wait3_back_in_if", W'(state1), W'(0));
    v = mk(32'h0080A283, 1'b0, 1, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
    run_instr(v, 0, -1, "lw_wait3");

    // Reset asserted during EX of add: back to IF, no write-back.
    apply_reset();
    v = mk(32'h002081B3, 1'b0, 0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
    run_instr(v, 3, 2, "add_abort");
    rst = 1'b0;
    check("abort_state_if", W'(state0), W'(0));
    check("abort_no_strobes", W'({loadpc0, pcsrc0, regwrite0, memwrite0}), W'(0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort_no_regwrite_c%0d", k), W'(regwrite0), W'(0));
      @(posedge clk);
    end
    apply_reset();
    run_instr(v, 0, -1, "add_after_abort");

    if (exp_q.size() != 0) check("queue_drained", W'(exp_q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
